withdraw_sequencer: RTL and testbench

Upstream controller for the `withdraw` note-dispense stage. It accepts a withdrawal request in note units and checks it against a held account balance. It then issues one `with_en` pulse per note and consumes the `count_down` acknowledge that `withdraw` returns, decrementing the balance per acknowledged note. It also accepts deposits while idle and reports completion, insufficient-funds and error status to the ATM top level.

---
 rtl/withdraw_sequencer.sv | 166 ++++++++++++++++
 tb/tb_withdraw_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/withdraw_sequencer.sv
// withdraw_sequencer: balance-checked note dispense controller driving the withdraw stage.
// Optional acknowledge timeout is enabled with `define WITHDRAW_TIMEOUT_EN.
module withdraw_sequencer #(
  parameter int unsigned BAL_W    = 16,
  parameter int unsigned AMT_W    = 8,
  parameter int unsigned INIT_BAL = 0,
  parameter int unsigned TMO      = 15
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             dep_valid,
  input  logic [AMT_W-1:0] dep_amt,
  input  logic             count_down,
  output logic             with_en,
  output logic [BAL_W-1:0] balance,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             insuff,
  output logic             err
);

  localparam int unsigned SUM_W = BAL_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [AMT_W-1:0] r_remaining;
  logic [AMT_W-1:0] w_remaining_nxt;
  logic [BAL_W-1:0] r_balance;
  logic [BAL_W-1:0] w_balance_nxt;
  logic             r_with_en;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;
  logic             r_insuff;
  logic             w_insuff_nxt;
  logic             w_err_nxt;

  // Saturating deposit sum, one bit wider to catch the carry
  logic [SUM_W-1:0] w_dep_sum;
  logic [BAL_W-1:0] w_dep_sat;

  assign w_dep_sum = {1'b0, r_balance} + SUM_W'(dep_amt);
  assign w_dep_sat = w_dep_sum[BAL_W] ? {BAL_W{1'b1}} : w_dep_sum[BAL_W-1:0];

`ifdef WITHDRAW_TIMEOUT_EN
  localparam int unsigned TMO_W = (TMO < 1) ? 1 : $clog2(TMO + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_cnt_nxt;
  logic             r_err;
`endif

  // Next-state, datapath and pulse decode
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_balance_nxt   = r_balance;
    w_insuff_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
`ifdef WITHDRAW_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_remaining_nxt = amount;
          w_state_nxt     = (amount == '0) ? S_DONE : S_CHECK;
        end else if (dep_valid) begin
          w_balance_nxt = w_dep_sat;
        end
      end
      S_CHECK: begin
        if (BAL_W'(r_remaining) > r_balance) begin
          w_insuff_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
`ifdef WITHDRAW_TIMEOUT_EN
        w_tmo_cnt_nxt = '0;
`endif
      end
      S_WAIT: begin
        if (count_down) begin
          w_balance_nxt   = r_balance - BAL_W'(1);
          w_remaining_nxt = r_remaining - AMT_W'(1);
          w_state_nxt     = (r_remaining == AMT_W'(1)) ? S_DONE : S_ISSUE;
        end
`ifdef WITHDRAW_TIMEOUT_EN
        // A late acknowledge on the expiry cycle still counts the note
        else if (r_tmo_cnt == TMO_W'(TMO)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
        end
`endif
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and Moore outputs registered from next state
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_balance   <= BAL_W'(INIT_BAL);
      r_with_en   <= 1'b0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_insuff    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
      r_balance   <= w_balance_nxt;
      r_with_en   <= (w_state_nxt == S_ISSUE);
      r_ready     <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt == S_CHECK) || (w_state_nxt == S_ISSUE) ||
                     (w_state_nxt == S_WAIT);
      r_done      <= (w_state_nxt == S_DONE);
      r_insuff    <= w_insuff_nxt;
    end
  end

`ifdef WITHDRAW_TIMEOUT_EN
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign err = r_err;
`else
  // Without the timeout the parameter and error pulse have no function
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO == 0) | w_err_nxt;
  assign err = 1'b0;
`endif

  assign with_en = r_with_en;
  assign balance = r_balance;
  assign ready   = r_ready;
  assign busy    = r_busy;
  assign done    = r_done;
  assign insuff  = r_insuff;

endmodule

// File: tb/tb_withdraw_sequencer.sv
// Scoreboard bench for withdraw_sequencer: stimulus queues expected with_en/done/insuff/err
// events, a negedge monitor pops and compares them. Covers the timeout path when WITHDRAW_TIMEOUT_EN is set.
module tb_withdraw_sequencer;

  localparam int unsigned BAL_W = 16;
  localparam int unsigned AMT_W = 8;
  localparam int unsigned TMO   = 15;

  localparam int K_DONE   = 0;
  localparam int K_INSUFF = 1;
  localparam int K_ERR    = 2;

  typedef struct {
    int kind;
    int due;
    int bal;
  } ev_t;

  logic             clk = 1'b0;
  logic             res;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             dep_valid;
  logic [AMT_W-1:0] dep_amt;
  logic             count_down;
  logic             with_en;
  logic [BAL_W-1:0] balance;
  logic             ready;
  logic             busy;
  logic             done;
  logic             insuff;
  logic             err;

  logic ack_en;
  int   cyc;
  int   n_assert;
  int   n_fail;
  ev_t  q_ev[$];
  int   q_en[$];

  withdraw_sequencer #(
    .BAL_W(BAL_W), .AMT_W(AMT_W), .INIT_BAL(0), .TMO(TMO)
  ) dut (
    .clk(clk), .res(res), .req(req), .amount(amount),
    .dep_valid(dep_valid), .dep_amt(dep_amt), .count_down(count_down),
    .with_en(with_en), .balance(balance), .ready(ready), .busy(busy),
    .done(done), .insuff(insuff), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural withdraw stage: acknowledge one cycle after each with_en
  always @(posedge clk or negedge res) begin
    if (!res) count_down <= 1'b0;
    else      count_down <= with_en & ack_en;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected events when the DUT presents them
  ev_t mon_e;
  int  mon_d;
  int  mon_kind;
  always @(negedge clk) begin
    if (res) begin
      if (with_en) begin
        if (q_en.size() == 0) chk("with_en unexpected", cyc, -1);
        else begin
          mon_d = q_en.pop_front();
          chk("with_en cycle", cyc, mon_d);
        end
      end
      if (done || insuff || err) begin
        mon_kind = done ? K_DONE : (insuff ? K_INSUFF : K_ERR);
        if (q_ev.size() == 0) chk("event unexpected", mon_kind, -1);
        else begin
          mon_e = q_ev.pop_front();
          chk("event kind", mon_kind, mon_e.kind);
          chk("event cycle", cyc, mon_e.due);
          chk("event balance", int'(balance), mon_e.bal);
          chk("busy at event", int'(busy), 0);
          chk("ready at event", int'(ready), int'(mon_e.kind != K_DONE));
        end
      end
      if (q_en.size() > 0 && q_en[0] < cyc) begin
        chk("with_en missing", cyc, q_en[0]);
        void'(q_en.pop_front());
      end
      if (q_ev.size() > 0 && q_ev[0].due < cyc) begin
        chk("event missing", cyc, q_ev[0].due);
        void'(q_ev.pop_front());
      end
    end
  end

  task automatic deposit(input int a, input int exp_bal);
    @(negedge clk);
    dep_valid = 1'b1;
    dep_amt   = AMT_W'(a);
    @(negedge clk);
    dep_valid = 1'b0;
    chk("deposit balance", int'(balance), exp_bal);
  endtask

  // lat counts cycles from the accepting edge to the status pulse
  task automatic do_req(input int a, input int kind, input int lat, input int bal,
                        input int n_en, input bit dep_with, input bit dep_busy);
    int  k;
    ev_t e;
    @(negedge clk);
    req       = 1'b1;
    amount    = AMT_W'(a);
    dep_valid = dep_with;
    dep_amt   = AMT_W'(9);
    @(posedge clk);
    #1;
    req       = 1'b0;
    dep_valid = dep_busy;
    dep_amt   = AMT_W'(100);
    k = cyc;
    e.kind = kind;
    e.due  = k + lat - 1;
    e.bal  = bal;
    q_ev.push_back(e);
    for (int i = 0; i < n_en; i++) q_en.push_back(k + 1 + 2 * i);
    if (dep_busy) begin
      repeat (3) @(posedge clk);
      #1 dep_valid = 1'b0;
    end
    while (cyc < k + lat) @(posedge clk);
  endtask

  task automatic chk_reset_outputs();
    chk("reset ready", int'(ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset with_en", int'(with_en), 0);
    chk("reset done", int'(done), 0);
    chk("reset insuff", int'(insuff), 0);
    chk("reset err", int'(err), 0);
    chk("reset balance", int'(balance), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    n_assert  = 0;
    n_fail    = 0;
    cyc       = 0;
    ack_en    = 1'b1;
    req       = 1'b0;
    amount    = '0;
    dep_valid = 1'b0;
    dep_amt   = '0;
    res       = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    @(negedge clk);
    res = 1'b1;

    // Deposit 50, withdraw 3 notes: with_en at +2,+4,+6, done at +8
    deposit(50, 50);
    do_req(3, K_DONE, 8, 47, 3, 1'b0, 1'b0);

    // Zero-note request completes the next cycle
    do_req(0, K_DONE, 1, 47, 0, 1'b0, 1'b0);

    // Coincident deposit dropped in favour of the request
    do_req(2, K_DONE, 6, 45, 2, 1'b1, 1'b0);

    // Deposit strobed while busy is ignored
    do_req(1, K_DONE, 4, 44, 1, 1'b0, 1'b1);
    @(negedge clk);
    chk("balance after busy deposit", int'(balance), 44);

    // Reset after the second acknowledge of a 4-note request
    @(negedge clk);
    req    = 1'b1;
    amount = AMT_W'(4);
    @(posedge clk);
    #1 req = 1'b0;
    k = cyc;
    q_en.push_back(k + 1);
    q_en.push_back(k + 3);
    repeat (5) @(posedge clk);
    #2 chk("balance before reset", int'(balance), 42);
    res = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    res = 1'b1;
    repeat (4) @(negedge clk);
    chk("balance after aborted request", int'(balance), 0);

    // Insufficient funds, then exact-balance request
    deposit(5, 5);
    do_req(6, K_INSUFF, 2, 5, 0, 1'b0, 1'b0);
    do_req(5, K_DONE, 12, 0, 5, 1'b0, 1'b0);

    // Fill to 65530, then saturate
    @(negedge clk);
    dep_valid = 1'b1;
    dep_amt   = AMT_W'(255);
    repeat (256) @(negedge clk);
    dep_amt = AMT_W'(250);
    @(negedge clk);
    dep_valid = 1'b0;
    chk("bulk deposit balance", int'(balance), 65530);
    deposit(200, 65535);
    deposit(1, 65535);

`ifdef WITHDRAW_TIMEOUT_EN
    // Acknowledge only the first note; err TMO cycles into the second wait
    begin
      ev_t e;
      @(negedge clk);
      req    = 1'b1;
      amount = AMT_W'(3);
      @(posedge clk);
      #1 req = 1'b0;
      k = cyc;
      e.kind = K_ERR;
      e.due  = k + int'(TMO) + 5;
      e.bal  = 65534;
      q_ev.push_back(e);
      q_en.push_back(k + 1);
      q_en.push_back(k + 3);
      repeat (2) @(posedge clk);
      #1 ack_en = 1'b0;
      while (cyc < k + int'(TMO) + 7) @(posedge clk);
      ack_en = 1'b1;
      @(negedge clk);
      chk("ready after timeout", int'(ready), 1);
      chk("balance after timeout", int'(balance), 65534);
    end
`endif

    repeat (5) @(negedge clk);
    chk("with_en queue drained", q_en.size(), 0);
    chk("event queue drained", q_ev.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
